// File: rtl/rails_tx.sv
// rails_tx: traffic source for the rails checker.
// Replays a push/pop script on an internal station stack to build a departure
// order, streams it to the checker as SYNC / header / cars / gap, and turns
// the checker's valid/result answer into a two-bit status code.
module rails_tx #(
  parameter int MAX_N = 10,
  parameter int DW    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DW-1:0]      n,
  input  logic [2*MAX_N-1:0] ops,
  output logic               busy,
  output logic [DW-1:0]      data,
  output logic               rx_reset,
  input  logic               rx_valid,
  input  logic               rx_result,
  output logic               done,
  output logic [1:0]         status
);

  // Op index must reach 2*MAX_N-1; one bit wider than a car number suffices.
  localparam int IW = DW + 1;

  localparam logic [1:0] ST_PASS   = 2'b00;
  localparam logic [1:0] ST_REJECT = 2'b01;
  localparam logic [1:0] ST_SCRIPT = 2'b10;
  localparam logic [1:0] ST_NORESP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_BUILD, S_SYNC, S_HDR, S_CARS, S_GAP, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [DW-1:0]      n_q, n_d;
  logic [2*MAX_N-1:0] ops_q, ops_d;
  logic [IW-1:0]      idx_q, idx_d;    // current script op
  logic [DW-1:0]      car_q, car_d;    // next car number to push
  logic [DW-1:0]      sp_q, sp_d;      // stack occupancy
  logic [DW-1:0]      wp_q, wp_d;      // perm buffer write pointer
  logic [DW-1:0]      rd_q, rd_d;      // car currently on the stream
  logic [1:0]         status_q, status_d;

  logic               push_en, pop_en, build_err;
  logic [IW-1:0]      last_op;

  logic [DW-1:0]      stack_mem [MAX_N];
  logic [DW-1:0]      perm_mem  [MAX_N];

  logic               busy_q, busy_d;
  logic               rx_reset_q, rx_reset_d;
  logic               done_q, done_d;
  logic [DW-1:0]      data_q, data_d;

  assign last_op = {n_q, 1'b0} - IW'(1);

  // State and datapath registers, plus the registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      ops_q      <= '0;
      idx_q      <= '0;
      car_q      <= '0;
      sp_q       <= '0;
      wp_q       <= '0;
      rd_q       <= '0;
      status_q   <= ST_PASS;
      busy_q     <= 1'b0;
      rx_reset_q <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      ops_q      <= ops_d;
      idx_q      <= idx_d;
      car_q      <= car_d;
      sp_q       <= sp_d;
      wp_q       <= wp_d;
      rd_q       <= rd_d;
      status_q   <= status_d;
      busy_q     <= busy_d;
      rx_reset_q <= rx_reset_d;
      done_q     <= done_d;
      data_q     <= data_d;
    end
  end

  // Stack and departure buffer storage.
  // NOTE: the arrays are deliberately left out of reset; the pointers are
  // reset and every entry is written before it can be read.
  always_ff @(posedge clk) begin
    if (push_en) stack_mem[sp_q] <= car_q;
    if (pop_en)  perm_mem[wp_q]  <= stack_mem[sp_q - DW'(1)];
  end

  // Next-state and datapath update: runs the script one op per BUILD cycle.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    ops_d     = ops_q;
    idx_d     = idx_q;
    car_d     = car_q;
    sp_d      = sp_q;
    wp_d      = wp_q;
    rd_d      = rd_q;
    status_d  = status_q;
    push_en   = 1'b0;
    pop_en    = 1'b0;
    build_err = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d   = n;
          ops_d = ops;
          idx_d = '0;
          car_d = DW'(1);
          sp_d  = '0;
          wp_d  = '0;
          if (n == '0 || n > DW'(MAX_N)) begin
            status_d = ST_SCRIPT;
            state_d  = S_DONE;
          end else begin
            state_d  = S_BUILD;
          end
        end
      end
      S_BUILD: begin
        if (ops_q[idx_q]) begin
          // A push once car N has already entered is a script error.
          if (car_q == n_q + DW'(1)) begin
            build_err = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + DW'(1);
            car_d   = car_q + DW'(1);
          end
        end else begin
          if (sp_q == '0) begin
            build_err = 1'b1;
          end else begin
            pop_en = 1'b1;
            sp_d   = sp_q - DW'(1);
            wp_d   = wp_q + DW'(1);
          end
        end
        if (build_err) begin
          status_d = ST_SCRIPT;
          state_d  = S_DONE;
        end else if (idx_q == last_op) begin
          state_d  = S_SYNC;
        end else begin
          idx_d    = idx_q + IW'(1);
        end
      end
      S_SYNC: state_d = S_HDR;
      S_HDR: begin
        rd_d    = '0;
        state_d = S_CARS;
      end
      S_CARS: begin
        if (rd_q == n_q - DW'(1)) state_d = S_GAP;
        else                      rd_d    = rd_q + DW'(1);
      end
      S_GAP: begin
        // The checker answers only in this cycle.
        status_d = rx_valid ? (rx_result ? ST_PASS : ST_REJECT) : ST_NORESP;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state, so outputs are registered with it.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    rx_reset_d = (state_d == S_SYNC);
    data_d     = '0;
    case (state_d)
      S_HDR:   data_d = n_q;
      S_CARS:  data_d = perm_mem[rd_d];
      default: data_d = '0;
    endcase
  end

  assign busy     = busy_q;
  assign data     = data_q;
  assign rx_reset = rx_reset_q;
  assign done     = done_q;
  assign status   = status_q;

endmodule

// File: tb/tb_rails_tx.sv
// Bench for rails_tx: table of directed frames, random scripts against a
// queue-based model of the station, and hand sequences for reset and start.
module tb_rails_tx;

  localparam int MAX_N = 10;
  localparam int DW    = 4;

  logic               clk = 1'b0;
  logic               reset, start, rx_valid, rx_result;
  logic [DW-1:0]      n;
  logic [2*MAX_N-1:0] ops;
  logic               busy, rx_reset, done;
  logic [DW-1:0]      data;
  logic [1:0]         status;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rails_tx #(.MAX_N(MAX_N), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .n         (n),
    .ops       (ops),
    .busy      (busy),
    .data      (data),
    .rx_reset  (rx_reset),
    .rx_valid  (rx_valid),
    .rx_result (rx_result),
    .done      (done),
    .status    (status)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: simulate the station with a queue used as a stack.
  int m_perm[MAX_N];
  int m_lat;
  bit m_err;

  function automatic void model(input int nn, input logic [2*MAX_N-1:0] o);
    int stk[$];
    int nxt = 1;
    int cnt = 0;
    m_err = 1'b0;
    if (nn < 1 || nn > MAX_N) begin
      m_err = 1'b1;
      m_lat = 1;
      return;
    end
    for (int k = 0; k < 2 * nn; k++) begin
      if (o[k]) begin
        if (nxt > nn) begin m_err = 1'b1; m_lat = k + 2; return; end
        stk.push_back(nxt);
        nxt++;
      end else begin
        if (stk.size() == 0) begin m_err = 1'b1; m_lat = k + 2; return; end
        m_perm[cnt] = stk.pop_back();
        cnt++;
      end
    end
    m_lat = 3 * nn + 4;
  endfunction

  // Expected {rx_reset, busy, done, data} in cycle c (start presented in cycle 0).
  function automatic logic [31:0] exp_out(input int c, input int nn);
    int rxr = 0;
    int d   = 0;
    if (!m_err) begin
      if (c == 2 * nn + 1) rxr = 1;
      if (c == 2 * nn + 2) d = nn;
      else if (c >= 2 * nn + 3 && c <= 3 * nn + 2) d = m_perm[c - 2 * nn - 3];
    end
    return 32'((rxr << 6) | (1 << 5) | ((c == m_lat ? 1 : 0) << 4) | d);
  endfunction

  // Drive one frame, capture every cycle, compare latency, status and stream.
  task automatic run_frame(input string name, input int nn, input logic [2*MAX_N-1:0] o,
                           input bit rv, input bit rr, input bit poke,
                           input bit use_exp, input int exp_st, input int exp_lat);
    logic [31:0] cap[128];
    int          c;
    int          es, el, lim;
    logic [1:0]  st;
    model(nn, o);
    if (use_exp) begin es = exp_st; el = exp_lat; end
    else begin es = m_err ? 2 : (rv ? (rr ? 0 : 1) : 3); el = m_lat; end
    @(negedge clk);
    n = DW'(nn); ops = o; start = 1'b1; rx_result = rr; rx_valid = 1'b0;
    c = 0; st = 2'bxx;
    while (c < 120) begin
      @(negedge clk);
      c++;
      start = poke && (c == 3);
      if (poke) begin n = '0; ops = ~o; end
      cap[c] = {25'b0, rx_reset, busy, done, data};
      rx_valid = rv && (c == 3 * nn + 3);
      if (done) begin st = status; break; end
    end
    check($sformatf("%s latency", name), c, el);
    check($sformatf("%s status", name), {30'b0, st}, es);
    lim = (c < el) ? c : el;
    for (int k = 1; k <= lim; k++)
      check($sformatf("%s cycle %0d {rxr,busy,done,data}", name, k), cap[k], exp_out(k, nn));
    // start raised during DONE must not launch a new frame
    start = poke;
    @(negedge clk);
    start = 1'b0; rx_valid = 1'b0;
    check($sformatf("%s idle after done", name), {31'b0, busy}, 0);
  endtask

  typedef struct {
    int                 nn;
    logic [2*MAX_N-1:0] o;
    bit                 rv;
    bit                 rr;
    bit                 poke;
    int                 st;
    int                 lat;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int nn, pushed, depth;
    logic [2*MAX_N-1:0] o;

    tbl[0]  = '{3,  20'b000111,       1, 1, 0, 0, 13};
    tbl[1]  = '{5,  20'b0101010101,   1, 1, 0, 0, 19};
    tbl[2]  = '{10, 20'h003FF,        1, 1, 0, 0, 34};
    tbl[3]  = '{3,  20'b111110,       1, 1, 0, 2, 2};
    tbl[4]  = '{0,  20'b000111,       1, 1, 0, 2, 1};
    tbl[5]  = '{11, 20'h003FF,        1, 1, 0, 2, 1};
    tbl[6]  = '{5,  20'b0101010101,   0, 1, 0, 3, 19};
    tbl[7]  = '{1,  20'b01,           1, 0, 0, 1, 7};
    tbl[8]  = '{4,  20'b00011111,     1, 1, 0, 2, 6};
    tbl[9]  = '{3,  20'b100101,       1, 1, 0, 2, 6};
    tbl[10] = '{3,  20'hFFFC7,        1, 1, 1, 0, 13};

    reset = 1'b1; start = 1'b0; n = '0; ops = '0; rx_valid = 1'b0; rx_result = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy",     {31'b0, busy},     0);
    check("reset data",     {28'b0, data},     0);
    check("reset rx_reset", {31'b0, rx_reset}, 0);
    check("reset done",     {31'b0, done},     0);
    check("reset status",   {30'b0, status},   0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].nn, tbl[i].o, tbl[i].rv, tbl[i].rr,
                tbl[i].poke, 1'b1, tbl[i].st, tbl[i].lat);

    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        nn = $urandom_range(1, MAX_N);
        pushed = 0; depth = 0;
        o = 20'($urandom);
        for (int k = 0; k < 2 * nn; k++) begin
          bit do_push;
          if (pushed == nn)    do_push = 1'b0;
          else if (depth == 0) do_push = 1'b1;
          else                 do_push = 1'($urandom_range(0, 1));
          o[k] = do_push;
          if (do_push) begin pushed++; depth++; end
          else depth--;
        end
      end else begin
        nn = $urandom_range(0, 12);
        o  = 20'($urandom);
      end
      run_frame($sformatf("rnd%0d", i), nn, o, 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0, 0);
    end

    // Leave a non-zero status behind so the reset below must clear it.
    run_frame("noresp", 2, 20'b0101, 1'b0, 1'b0, 1'b0, 1'b1, 3, 10);

    // Reset in the middle of CARS: second car (3) is on the stream at cycle 12.
    @(negedge clk);
    n = 4'd4; ops = 20'h0000F; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("cars before reset", {28'b0, data}, 3);
    reset = 1'b1;
    @(negedge clk);
    check("midreset busy",     {31'b0, busy},     0);
    check("midreset data",     {28'b0, data},     0);
    check("midreset rx_reset", {31'b0, rx_reset}, 0);
    check("midreset done",     {31'b0, done},     0);
    check("midreset status",   {30'b0, status},   0);
    reset = 1'b0;

    run_frame("after reset", 3, 20'b000111, 1'b1, 1'b1, 1'b1, 1'b1, 0, 13);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
